// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types: hazard-controller FSM states and M-field bit positions.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  localparam int MEM_READ_BIT  = 1;
  localparam int MEM_WRITE_BIT = 0;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use stalls, branch flushes,
// and a req/ack data-memory handshake with timeout that freezes the pipe while busy.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             ex_mem_M_i,
  input  logic                   id_ex_memread_i,
  input  logic [4:0]             id_ex_rt_i,
  input  logic [4:0]             if_id_rs_i,
  input  logic [4:0]             if_id_rt_i,
  input  logic                   branch_taken_i,
  input  logic                   mem_ack_i,
  output logic                   mem_req_o,
  output logic                   mem_we_o,
  output logic                   pc_en_o,
  output logic                   if_id_en_o,
  output logic                   id_ex_en_o,
  output logic                   ex_mem_en_o,
  output logic                   mem_wb_en_o,
  output logic                   if_id_flush_o,
  output logic                   id_ex_flush_o,
  output logic                   mem_wb_bubble_o,
  output logic                   err_o,
  output logic [STALL_CNT_W-1:0] stall_cycles_o
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_e            state_q, state_d;
  logic              err_q, err_d;
  logic              access, mstall, load_use;
  logic [WAIT_W-1:0] wait_cnt;

  assign access   = ex_mem_M_i[MEM_READ_BIT] | ex_mem_M_i[MEM_WRITE_BIT];
  assign mstall   = access & ~mem_ack_i & (state_q != ERROR);
  assign load_use = id_ex_memread_i & (id_ex_rt_i != 5'd0) &
                    ((id_ex_rt_i == if_id_rs_i) | (id_ex_rt_i == if_id_rt_i));

  // Leaving MEM_WAIT without an ack only happens if the access vanished; treat it as done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (mstall) state_d = MEM_WAIT;
      MEM_WAIT: begin
        if (!mstall) begin
          state_d = RUN;
        end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
          state_d = ERROR;
        end
      end
      default:  state_d = state_q;
    endcase
  end

  assign err_d = err_q | (state_d == ERROR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // Held at 0 outside a stall, so the first stall cycle takes it to 1.
  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (mstall),
    .clr_i (~mstall),
    .cnt_o (wait_cnt)
  );

  sat_counter #(.W(STALL_CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (mstall),
    .clr_i (1'b0),
    .cnt_o (stall_cycles_o)
  );

  always_comb begin
    mem_req_o       = 1'b0;
    pc_en_o         = 1'b0;
    if_id_en_o      = 1'b0;
    id_ex_en_o      = 1'b0;
    ex_mem_en_o     = 1'b0;
    mem_wb_en_o     = 1'b0;
    if_id_flush_o   = 1'b0;
    id_ex_flush_o   = 1'b0;
    mem_wb_bubble_o = 1'b0;
    if (rst_n && (state_q != ERROR)) begin
      mem_req_o   = access;
      pc_en_o     = 1'b1;
      if_id_en_o  = 1'b1;
      id_ex_en_o  = 1'b1;
      ex_mem_en_o = 1'b1;
      mem_wb_en_o = 1'b1;
      if (mstall) begin
        pc_en_o         = 1'b0;
        if_id_en_o      = 1'b0;
        id_ex_en_o      = 1'b0;
        ex_mem_en_o     = 1'b0;
        mem_wb_bubble_o = 1'b1;
      end else if (branch_taken_i) begin
        if_id_flush_o = 1'b1;
        id_ex_flush_o = 1'b1;
      end else if (load_use) begin
        pc_en_o       = 1'b0;
        if_id_en_o    = 1'b0;
        id_ex_flush_o = 1'b1;
      end
    end
  end

  assign mem_we_o = ex_mem_M_i[MEM_WRITE_BIT];
  assign err_o    = err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a cycle-level reference model checked every negedge.
module tb_pipe_hazard_ctrl;

  localparam int TO    = 4;
  localparam int CW    = 4;
  localparam int SATMX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    ex_mem_M = 2'b00;
  logic          id_ex_memread = 1'b0;
  logic [4:0]    id_ex_rt = 5'd0;
  logic [4:0]    if_id_rs = 5'd0;
  logic [4:0]    if_id_rt = 5'd0;
  logic          branch = 1'b0;
  logic          ack = 1'b0;
  logic          mem_req, mem_we, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic          if_id_flush, id_ex_flush, bubble, err;
  logic [CW-1:0] stall_cnt;

  int n_chk = 0;
  int n_fail = 0;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .STALL_CNT_W(CW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ex_mem_M_i      (ex_mem_M),
    .id_ex_memread_i (id_ex_memread),
    .id_ex_rt_i      (id_ex_rt),
    .if_id_rs_i      (if_id_rs),
    .if_id_rt_i      (if_id_rt),
    .branch_taken_i  (branch),
    .mem_ack_i       (ack),
    .mem_req_o       (mem_req),
    .mem_we_o        (mem_we),
    .pc_en_o         (pc_en),
    .if_id_en_o      (if_id_en),
    .id_ex_en_o      (id_ex_en),
    .ex_mem_en_o     (ex_mem_en),
    .mem_wb_en_o     (mem_wb_en),
    .if_id_flush_o   (if_id_flush),
    .id_ex_flush_o   (id_ex_flush),
    .mem_wb_bubble_o (bubble),
    .err_o           (err),
    .stall_cycles_o  (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: error flag, length of the current run of stalled cycles, total stalls.
  logic m_err;
  int   m_run;
  int   m_total;

  function automatic logic [9:0] model_out();
    logic [4:0] en;
    logic       f1, f2, bub, stall, lu;
    if (!rst_n) return 10'd0;
    if (m_err) return 10'b00000_0000_1;
    stall = (ex_mem_M != 2'b00) && !ack;
    lu    = id_ex_memread && (id_ex_rt != 0) && (id_ex_rt == if_id_rs || id_ex_rt == if_id_rt);
    en = 5'b11111; f1 = 1'b0; f2 = 1'b0; bub = 1'b0;
    if (stall) begin
      en = 5'b00001; bub = 1'b1;
    end else if (branch) begin
      f1 = 1'b1; f2 = 1'b1;
    end else if (lu) begin
      en = 5'b00111; f2 = 1'b1;
    end
    return {en, f1, f2, bub, (ex_mem_M != 2'b00), 1'b0};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_err = 1'b0; m_run = 0; m_total = 0;
    end else if (!m_err) begin
      if ((ex_mem_M != 2'b00) && !ack) begin
        m_run++;
        if (m_total < SATMX) m_total++;
        if (m_run == TO + 1) m_err = 1'b1;
      end else begin
        m_run = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("outputs", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                    if_id_flush, id_ex_flush, bubble, mem_req, err}, model_out());
    chk("stall_cycles", stall_cnt, m_total);
    if (mem_req) chk("mem_we", mem_we, ex_mem_M[0]);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int n;

  initial begin
    repeat (2) cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_en", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, 5'h1f);
    chk("idle_req_err_flush", {mem_req, err, if_id_flush, id_ex_flush, bubble}, 0);
    chk("idle_stall_cnt", stall_cnt, 0);

    // Read acknowledged in the same cycle.
    cyc(); ex_mem_M = 2'b10; ack = 1'b1;
    @(negedge clk);
    chk("rd_req_we", {mem_req, mem_we}, 2'b10);
    chk("rd_pc_en", pc_en, 1);
    cyc(); ex_mem_M = 2'b00; ack = 1'b0;
    @(negedge clk);
    chk("rd_no_stall", stall_cnt, 0);

    // Write acknowledged 3 cycles after request.
    cyc(); ex_mem_M = 2'b01; n = 0;
    repeat (3) begin
      @(negedge clk);
      if (!pc_en && !if_id_en && !id_ex_en && !ex_mem_en && mem_wb_en && bubble) n++;
      cyc();
    end
    ack = 1'b1;
    @(negedge clk);
    chk("wr_stall_len", n, 3);
    chk("wr_advance", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, bubble}, 6'b111110);
    cyc(); ex_mem_M = 2'b00; ack = 1'b0;
    @(negedge clk);
    chk("wr_stall_cnt", stall_cnt, 3);

    // Load-use hazards.
    cyc(); id_ex_memread = 1'b1; id_ex_rt = 5'd5; if_id_rs = 5'd5;
    @(negedge clk);
    chk("lu_rs", {pc_en, if_id_en, id_ex_flush, id_ex_en}, 4'b0011);
    cyc(); id_ex_rt = 5'd0; if_id_rt = 5'd0;
    @(negedge clk);
    chk("lu_r0", {pc_en, if_id_en, id_ex_flush}, 3'b110);
    cyc(); id_ex_rt = 5'd7; if_id_rt = 5'd7;
    @(negedge clk);
    chk("lu_rt", {pc_en, if_id_en, id_ex_flush}, 3'b001);
    cyc(); id_ex_rt = 5'd5; branch = 1'b1;
    @(negedge clk);
    chk("lu_branch", {if_id_flush, id_ex_flush, pc_en, if_id_en}, 4'b1111);

    // Branch during a memory stall is held off until the advance cycle.
    cyc(); id_ex_memread = 1'b0; id_ex_rt = 5'd0; if_id_rs = 5'd0; if_id_rt = 5'd0;
    ex_mem_M = 2'b10;
    @(negedge clk);
    chk("br_mstall", {if_id_flush, id_ex_flush, bubble}, 3'b001);
    cyc(); ack = 1'b1;
    @(negedge clk);
    chk("br_advance", {if_id_flush, id_ex_flush, pc_en}, 3'b111);
    cyc(); ex_mem_M = 2'b00; ack = 1'b0; branch = 1'b0;
    @(negedge clk);
    chk("cnt_4", stall_cnt, 4);

    // Two 4-cycle writes (both at the edge of the timeout, not over it).
    repeat (2) begin
      cyc(); ex_mem_M = 2'b11;
      repeat (4) cyc();
      ack = 1'b1;
      cyc(); ex_mem_M = 2'b00; ack = 1'b0;
    end
    @(negedge clk);
    chk("cnt_12", stall_cnt, 12);

    // Timeout: 1 RUN stall cycle plus TO wait cycles, then ERROR.
    cyc(); ex_mem_M = 2'b01;
    repeat (TO + 1) begin
      @(negedge clk);
      chk("to_pre_err", err, 0);
      cyc();
    end
    @(negedge clk);
    chk("to_err", {err, mem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, 7'b1000000);
    chk("cnt_saturated", stall_cnt, 15);
    cyc(); ack = 1'b1; branch = 1'b1;
    @(negedge clk);
    chk("err_sticky", {err, mem_req, pc_en, mem_wb_en, if_id_flush}, 5'b10000);

    // Asynchronous reset mid-cycle.
    cyc(); #2 rst_n = 1'b0; #1;
    chk("arst_outs", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, mem_req, err}, 0);
    chk("arst_cnt", stall_cnt, 0);
    cyc(); ex_mem_M = 2'b00; ack = 1'b0; branch = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, mem_req, err}, 7'b1111100);

    // Reset during a wait abandons the access immediately.
    cyc(); ex_mem_M = 2'b01;
    cyc();
    @(negedge clk);
    chk("wait_req", mem_req, 1);
    #1 rst_n = 1'b0;
    #1 chk("wait_abandon", {mem_req, bubble}, 0);
    cyc(); ex_mem_M = 2'b00; rst_n = 1'b1;
    @(negedge clk);
    chk("final_idle", {pc_en, mem_req, err, stall_cnt}, {3'b100, 4'd0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the five-stage MIPS pipeline. It drives the enable and flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It detects load-use hazards in ID and flushes on taken branches resolved in EX. It sequences each data-memory access in MEM through a req/ack handshake with a timeout, freezing the pipeline while the memory is busy.

## Interface
Parameters:
- MEM_TIMEOUT, 64: max wait cycles for mem_ack_i before entering ERROR (≥1)
- STALL_CNT_W, 16: width of the saturating stall-cycle counter

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- ex_mem_M_i  in  2  M field held in EX/MEM: bit1 MemRead, bit0 MemWrite
- id_ex_memread_i  in  1  MemRead of the instruction in ID/EX
- id_ex_rt_i  in  5  rt (load destination) in ID/EX
- if_id_rs_i, if_id_rt_i  in  5 each  source registers of the instruction in IF/ID
- branch_taken_i  in  1  taken branch/jump resolved in EX this cycle
- mem_ack_i  in  1  data memory completes the presented access this cycle
- mem_req_o  out  1  data-memory access request
- mem_we_o  out  1  request is a write (valid with mem_req_o)
- pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o  out  1 each  register load enables
- if_id_flush_o, id_ex_flush_o  out  1 each  load a bubble (all-zero controls) instead of data
- mem_wb_bubble_o  out  1  MEM/WB loads a bubble (WB=0)
- err_o  out  1  sticky memory-timeout error
- stall_cycles_o  out  STALL_CNT_W  saturating count of memory-stall cycles

## Operation
- States: RUN, MEM_WAIT, ERROR. Reset state is RUN.
- access = ex_mem_M_i[1] | ex_mem_M_i[0]. mem_we_o = ex_mem_M_i[0]. mem_req_o = access in RUN/MEM_WAIT and 0 in ERROR. If both M bits are set, the access is treated as a write.
- Memory stall (mstall) = access & ~mem_ack_i, in RUN or MEM_WAIT. While mstall holds:
  - all five enables are 0 except mem_wb_en_o = 1.
  - mem_wb_bubble_o = 1.
  - all flushes are 0.
- RUN → MEM_WAIT on mstall. The wait counter loads 1.
- MEM_WAIT:
  - on mem_ack_i: → RUN. This is the advance cycle; all enables are 1.
  - else, counter == MEM_TIMEOUT: → ERROR.
  - else: counter increments.
- ERROR:
  - all enables 0, mem_req_o 0, err_o 1.
  - leaves only by reset.
- Load-use, evaluated only when there is no mstall and the state is not ERROR: id_ex_memread_i & id_ex_rt_i≠0 & (id_ex_rt_i==if_id_rs_i | id_ex_rt_i==if_id_rt_i) gives:
  - pc_en_o = 0, if_id_en_o = 0
  - id_ex_flush_o = 1
  - id_ex_en_o, ex_mem_en_o, mem_wb_en_o = 1
- Branch (no mstall, not ERROR):
  - if_id_flush_o = 1 and id_ex_flush_o = 1, all enables 1.
  - Branch overrides load-use, because the hazarding instruction is squashed.
- Priority: ERROR > mstall > branch > load-use > normal (all enables 1, flushes 0).
- stall_cycles_o increments in every mstall cycle and saturates at all-ones.

## Timing
- All controls are combinational from state and inputs. State, counters and err_o are registered.
- While rst_n is low, asynchronously:
  - state RUN, counters 0, err_o 0.
  - all enables 0, flushes 0, mem_wb_bubble_o 0, mem_req_o 0.
- After reset with all inputs 0: enables 1, everything else 0.
- Memory latency: if ack arrives k cycles after mem_req_o first rises (k=0 means the same cycle), the pipeline stalls exactly k cycles.
- mem_req_o and mem_we_o are stable across a wait because EX/MEM is frozen.
- Reset asserted mid-wait abandons the access; mem_req_o drops immediately.
- A branch_taken_i during mstall is ignored. EX is frozen, so the branch is re-presented on the advance cycle.
- ERROR is entered on the cycle after the MEM_TIMEOUT-th unacknowledged wait cycle.

## Structure
- Package pipe_ctrl_pkg holds:
  - state enum {RUN, MEM_WAIT, ERROR}
  - M-field bit indices MEM_READ_BIT=1, MEM_WRITE_BIT=0
  - shared with the pipeline-register and control-unit blocks.
- Sub-module sat_counter (parameter W; inc, clr inputs) is used for both the wait counter and stall_cycles_o.

## Test plan
- Reset, then all inputs 0 → all enables 1, flushes 0, mem_req_o 0, err_o 0. Assert rst_n low mid-run → enables 0 asynchronously.
- ex_mem_M_i=2'b10 with mem_ack_i=1 in the same cycle → mem_req_o=1, mem_we_o=0, no stall, stall_cycles_o stays 0.
- ex_mem_M_i=2'b01, ack 3 cycles after request:
  - 3 cycles with pc_en..ex_mem_en=0 and mem_wb_bubble_o=1, then one advance cycle with all enables 1.
  - stall_cycles_o=3.
- id_ex_memread_i=1, id_ex_rt_i=5, if_id_rs_i=5:
  - pc_en_o=0, if_id_en_o=0, id_ex_flush_o=1 for one cycle.
  - With id_ex_rt_i=0 instead → no stall.
- Load-use and branch_taken_i together → if_id_flush_o=1, id_ex_flush_o=1, pc_en_o=1.
- MEM_TIMEOUT=4, access with no ack → after 4 wait cycles err_o=1, mem_req_o=0, all enables 0. ERROR persists until rst_n low.
